// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the QSPI arbiter.
//   state_t : arbiter FSM states (IDLE -> XFER -> GAP -> IDLE)
//   ADDR_W  : byte address width of each requester slice
//   DATA_W  : data word width (one QSPI word = 16 bits)
//   STRB_W  : byte strobe width per word
//   LEN_W   : burst length field width (words minus 1)
//   GUARD_W : guard-time field width
package qspi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int ADDR_W  = 24;
    localparam int DATA_W  = 16;
    localparam int STRB_W  = 2;
    localparam int LEN_W   = 4;
    localparam int GUARD_W = 4;

endpackage

// File: rtl/rr_picker.sv
// Round-robin winner selection with optional debug-port override.
// Ports:
//   i_req    : request vector, one bit per requester
//   i_ptr    : requester index that has first claim this round
//   o_winner : index of the selected requester (0 when nothing is requested)
//   o_any    : at least one request is pending
// NUM_REQ must be at least 2.
module rr_picker
    import qspi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DEBUG_PRIO = 1
) (
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
    output logic [$clog2(NUM_REQ)-1:0] o_winner,
    output logic                       o_any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    logic w_found;
    int   w_idx;

    always_comb begin
        o_winner = '0;
        o_any    = |i_req;
        w_found  = 1'b0;
        w_idx    = 0;
        // Scan i_ptr, i_ptr+1, ... wrapping; first set bit wins.
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(i_ptr) + k) % NUM_REQ;
            if (!w_found && i_req[w_idx]) begin
                w_found  = 1'b1;
                o_winner = w_idx[IDX_W-1:0];
            end
        end
        // The debug port jumps the queue whenever it asks.
        if (DEBUG_PRIO != 0 && i_req[0]) begin
            o_winner = '0;
        end
    end

endmodule

// File: rtl/qspi_arbiter.sv
// Shares one QSPI memory controller between NUM_REQ requesters.
// A winner is picked in IDLE, its slice is muxed to the controller for the
// whole burst (XFER), then a guard gap (GAP) keeps CE deasserted for
// guard_time+1 cycles before the next arbitration. A watchdog aborts a
// burst that waits too long for q_ready.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid         : per-requester request, held until last ready or abandoned
//   req_addr/wdata/wstrb/xfer_len/ce_ctrl : packed per-requester request fields
//   req_ready         : per-word ready, only toward the granted requester
//   req_rdata         : q_rdata broadcast to all requesters
//   q_addr/q_wdata/q_wstrb/q_xfer_len/q_ce_ctrl : granted slice to controller
//   q_valid           : request to controller
//   q_ready           : controller word done, one pulse per 16-bit word
//   q_rdata           : controller read data
//   guard_time        : extra idle cycles after each burst
//   grant_id          : current / last granted requester
//   busy              : arbiter not idle
//   timeout_err       : one-cycle pulse when the watchdog aborts a burst
//
// Handshake: q_valid mirrors req_valid of the granted requester while in
// XFER. Each cycle with q_valid high and q_ready high transfers one word;
// q_ready is forwarded as req_ready only to the granted requester and only
// in XFER. A q_ready arriving in the same cycle as the requester drops
// req_valid still counts as a transferred word.
module qspi_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int CHIP_SELECTS = 2,
    parameter int DEBUG_PRIO   = 1,
    parameter int TIMEOUT      = 1023
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_REQ-1:0]                req_valid,
    input  logic [NUM_REQ*24-1:0]             req_addr,
    input  logic [NUM_REQ*16-1:0]             req_wdata,
    input  logic [NUM_REQ*2-1:0]              req_wstrb,
    input  logic [NUM_REQ*4-1:0]              req_xfer_len,
    input  logic [NUM_REQ*CHIP_SELECTS-1:0]   req_ce_ctrl,
    output logic [NUM_REQ-1:0]                req_ready,
    output logic [15:0]                       req_rdata,
    output logic [23:0]                       q_addr,
    output logic [15:0]                       q_wdata,
    output logic [1:0]                        q_wstrb,
    output logic [3:0]                        q_xfer_len,
    output logic [CHIP_SELECTS-1:0]           q_ce_ctrl,
    output logic                              q_valid,
    input  logic                              q_ready,
    input  logic [15:0]                       q_rdata,
    input  logic [3:0]                        guard_time,
    output logic [$clog2(NUM_REQ)-1:0]        grant_id,
    output logic                              busy,
    output logic                              timeout_err
);

    localparam int GNT_W  = $clog2(NUM_REQ);
    localparam int WDOG_W = $clog2(TIMEOUT + 1);

    state_t             r_state;
    logic [GNT_W-1:0]   r_grant;
    logic [GNT_W-1:0]   r_rr_ptr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [WDOG_W-1:0]  r_wdog;
    logic [GUARD_W-1:0] r_gap_cnt;
    logic               r_timeout_err;

    logic [GNT_W-1:0]   w_winner;
    logic               w_any;
    logic [GNT_W-1:0]   w_next_ptr;
    logic [LEN_W-1:0]   w_win_len;
    logic               w_gnt_valid;

    rr_picker #(
        .NUM_REQ    (NUM_REQ),
        .DEBUG_PRIO (DEBUG_PRIO)
    ) u_picker (
        .i_req    (req_valid),
        .i_ptr    (r_rr_ptr),
        .o_winner (w_winner),
        .o_any    (w_any)
    );

    // Pointer moves to the requester after the winner so it gets first claim next time.
    always_comb begin
        if (int'(w_winner) == NUM_REQ - 1) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = w_winner + 1'b1;
        end
    end

    // Burst length of the prospective winner, latched once at grant time.
    always_comb begin
        w_win_len = req_xfer_len[0 +: LEN_W];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == GNT_W'(i)) begin
                w_win_len = req_xfer_len[i*LEN_W +: LEN_W];
            end
        end
    end

    // Output slice follows grant_id in every state, so after reset slice 0 shows.
    always_comb begin
        q_addr     = req_addr[0 +: ADDR_W];
        q_wdata    = req_wdata[0 +: DATA_W];
        q_wstrb    = req_wstrb[0 +: STRB_W];
        q_xfer_len = req_xfer_len[0 +: LEN_W];
        q_ce_ctrl  = req_ce_ctrl[0 +: CHIP_SELECTS];
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == GNT_W'(i)) begin
                q_addr     = req_addr[i*ADDR_W +: ADDR_W];
                q_wdata    = req_wdata[i*DATA_W +: DATA_W];
                q_wstrb    = req_wstrb[i*STRB_W +: STRB_W];
                q_xfer_len = req_xfer_len[i*LEN_W +: LEN_W];
                q_ce_ctrl  = req_ce_ctrl[i*CHIP_SELECTS +: CHIP_SELECTS];
            end
        end
    end

    assign w_gnt_valid = req_valid[r_grant];

    // q_ready outside XFER is dropped here so it can never look like a word.
    always_comb begin
        req_ready = '0;
        if (r_state == XFER && q_ready) begin
            req_ready[r_grant] = 1'b1;
        end
    end

    assign q_valid     = (r_state == XFER) && w_gnt_valid;
    assign req_rdata   = q_rdata;
    assign grant_id    = r_grant;
    assign busy        = (r_state != IDLE);
    assign timeout_err = r_timeout_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_len         <= '0;
            r_word_cnt    <= '0;
            r_wdog        <= '0;
            r_gap_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_winner;
                        r_len      <= w_win_len;
                        r_rr_ptr   <= w_next_ptr;
                        r_word_cnt <= '0;
                        r_wdog     <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    // Priority: a word done (incl. the last) beats abandon and timeout.
                    if (q_ready) begin
                        if (r_word_cnt == r_len) begin
                            r_gap_cnt <= guard_time;
                            r_state   <= GAP;
                        end else begin
                            r_word_cnt <= r_word_cnt + 1'b1;
                            r_wdog     <= '0;
                        end
                    end else if (!w_gnt_valid) begin
                        r_gap_cnt <= guard_time;
                        r_state   <= GAP;
                    end else if (r_wdog == WDOG_W'(TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_gap_cnt     <= guard_time;
                        r_state       <= GAP;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                GAP: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_qspi_arbiter.sv
// Directed bench for qspi_arbiter with a transaction-level reference model
// (owner / remaining-gap bookkeeping) checked against the DUT every cycle,
// plus hand-computed expectations on grant order, word counts and pulses.
module tb_qspi_arbiter;

    localparam int NR = 4;
    localparam int CS = 2;
    localparam int DP = 1;
    localparam int TO = 15;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NR-1:0]        req_valid;
    logic [NR*24-1:0]     req_addr;
    logic [NR*16-1:0]     req_wdata;
    logic [NR*2-1:0]      req_wstrb;
    logic [NR*4-1:0]      req_xfer_len;
    logic [NR*CS-1:0]     req_ce_ctrl;
    logic [NR-1:0]        req_ready;
    logic [15:0]          req_rdata;
    logic [23:0]          q_addr;
    logic [15:0]          q_wdata;
    logic [1:0]           q_wstrb;
    logic [3:0]           q_xfer_len;
    logic [CS-1:0]        q_ce_ctrl;
    logic                 q_valid;
    logic                 q_ready;
    logic [15:0]          q_rdata;
    logic [3:0]           guard_time;
    logic [1:0]           grant_id;
    logic                 busy;
    logic                 timeout_err;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    qspi_arbiter #(
        .NUM_REQ      (NR),
        .CHIP_SELECTS (CS),
        .DEBUG_PRIO   (DP),
        .TIMEOUT      (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_wstrb    (req_wstrb),
        .req_xfer_len (req_xfer_len),
        .req_ce_ctrl  (req_ce_ctrl),
        .req_ready    (req_ready),
        .req_rdata    (req_rdata),
        .q_addr       (q_addr),
        .q_wdata      (q_wdata),
        .q_wstrb      (q_wstrb),
        .q_xfer_len   (q_xfer_len),
        .q_ce_ctrl    (q_ce_ctrl),
        .q_valid      (q_valid),
        .q_ready      (q_ready),
        .q_rdata      (q_rdata),
        .guard_time   (guard_time),
        .grant_id     (grant_id),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    // ---------------- checker ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_owner  : requester currently holding the bus, -1 when none
    // m_gap_left: guard cycles still to spend before arbitration may resume
    int  m_owner    = -1;
    int  m_len      = 0;
    int  m_words    = 0;
    int  m_stall    = 0;
    int  m_gap_left = 0;
    int  m_last     = 0;
    int  m_ptr      = 0;
    bit  m_to       = 1'b0;
    int  grant_log[$];
    int  words_log[$];

    task automatic model_reset();
        m_owner = -1; m_len = 0; m_words = 0; m_stall = 0;
        m_gap_left = 0; m_last = 0; m_ptr = 0; m_to = 1'b0;
        grant_log.delete();
        words_log.delete();
    endtask

    task automatic end_burst();
        words_log.push_back(m_words);
        m_owner    = -1;
        m_gap_left = int'(guard_time) + 1;
    endtask

    task automatic model_step();
        int w;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (q_ready) begin
                m_words++;
                m_stall = 0;
                if (m_words == m_len + 1) end_burst();
            end else if (!req_valid[m_owner]) begin
                end_burst();
            end else if (m_stall == TO) begin
                m_to = 1'b1;
                end_burst();
            end else begin
                m_stall++;
            end
        end else if (m_gap_left > 0) begin
            m_gap_left--;
        end else if (req_valid != '0) begin
            w = -1;
            if (DP != 0 && req_valid[0]) w = 0;
            for (int k = 0; k < NR; k++) begin
                if (w < 0 && req_valid[(m_ptr + k) % NR]) w = (m_ptr + k) % NR;
            end
            m_owner = w;
            m_last  = w;
            m_len   = int'(req_xfer_len[w*4 +: 4]);
            m_words = 0;
            m_stall = 0;
            m_ptr   = (w + 1) % NR;
            grant_log.push_back(w);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    task automatic compare_outputs();
        logic [NR-1:0] e_rdy;
        logic          e_qv;
        e_rdy = '0;
        e_qv  = 1'b0;
        if (m_owner >= 0) begin
            e_qv = req_valid[m_owner];
            if (q_ready) e_rdy[m_owner] = 1'b1;
        end
        chk("cyc_q_valid",     32'(q_valid),     32'(e_qv));
        chk("cyc_req_ready",   32'(req_ready),   32'(e_rdy));
        chk("cyc_busy",        32'(busy),        32'((m_owner >= 0) || (m_gap_left > 0)));
        chk("cyc_grant_id",    32'(grant_id),    32'(m_last));
        chk("cyc_timeout_err", 32'(timeout_err), 32'(m_to));
        chk("cyc_q_addr",      32'(q_addr),      32'(req_addr[m_last*24 +: 24]));
        chk("cyc_q_wdata",     32'(q_wdata),     32'(req_wdata[m_last*16 +: 16]));
        chk("cyc_q_wstrb",     32'(q_wstrb),     32'(req_wstrb[m_last*2 +: 2]));
        chk("cyc_q_xfer_len",  32'(q_xfer_len),  32'(req_xfer_len[m_last*4 +: 4]));
        chk("cyc_q_ce_ctrl",   32'(q_ce_ctrl),   32'(req_ce_ctrl[m_last*CS +: CS]));
        chk("cyc_req_rdata",   32'(req_rdata),   32'(q_rdata));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_outputs();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        q_rdata = q_rdata + 16'h1357;
    endtask

    task automatic do_reset();
        req_valid = '0;
        q_ready   = 1'b0;
        rst_n     = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_req(input int id, input bit v, input logic [3:0] len);
        req_xfer_len[id*4 +: 4] = len;
        req_valid[id]           = v;
    endtask

    task automatic run_until_grants(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (grant_log.size() < n && k < budget) begin
            tick();
            k++;
        end
        if (grant_log.size() < n) begin
            n_total++;
            n_bad++;
            $display("FAIL %s: %0d grants seen, required %0d within %0d cycles", name, grant_log.size(), n, budget);
        end
    endtask

    // Requester with a single-word burst gets its word, then releases.
    task automatic finish_burst(input int id);
        q_ready = 1'b1;
        tick();
        req_valid[id] = 1'b0;
        q_ready       = 1'b0;
    endtask

    function automatic int gl(input int i);
        return (i < grant_log.size()) ? grant_log[i] : 99;
    endfunction

    function automatic int wl(input int i);
        return (i < words_log.size()) ? words_log[i] : 99;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        req_valid    = '0;
        req_xfer_len = '0;
        q_ready      = 1'b0;
        q_rdata      = 16'h0101;
        guard_time   = 4'd0;
        for (int i = 0; i < NR; i++) begin
            req_addr[i*24 +: 24]   = 24'(32'h0010_0000 * (i + 1) + 32'h0000_00AB);
            req_wdata[i*16 +: 16]  = 16'(32'hA000 + 32'h0111 * i);
            req_wstrb[i*2 +: 2]    = 2'(i);
            req_ce_ctrl[i*CS +: CS] = (i % 2 == 0) ? 2'b01 : 2'b10;
        end
        #1;
        do_reset();
        chk("rst_busy",      32'(busy),        32'd0);
        chk("rst_q_valid",   32'(q_valid),     32'd0);
        chk("rst_grant_id",  32'(grant_id),    32'd0);
        chk("rst_timeout",   32'(timeout_err), 32'd0);
        chk("rst_q_addr",    32'(q_addr),      32'h0010_00AB);

        // 1: single read, ready on the third XFER cycle, guard 2 -> 3 GAP cycles
        guard_time = 4'd2;
        set_req(2, 1'b1, 4'd0);
        tick();
        chk("t1_q_valid_x1", 32'(q_valid),  32'd1);
        chk("t1_grant",      32'(grant_id), 32'd2);
        tick();
        tick();
        chk("t1_q_valid_x3", 32'(q_valid),  32'd1);
        q_ready = 1'b1;
        #1;
        chk("t1_req_ready",  32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b0;
        #1;
        chk("t1_ready_in_gap_ignored", 32'(req_ready), 32'd0);
        chk("t1_q_valid_gap",          32'(q_valid),   32'd0);
        q_ready = 1'b0;
        tick();
        tick();
        chk("t1_busy_gap3",  32'(busy), 32'd1);
        tick();
        chk("t1_busy_idle",  32'(busy), 32'd0);
        chk("t1_words",      32'(wl(0)), 32'd1);

        // 2: round robin over 1,2,3 with continuous requests
        do_reset();
        guard_time = 4'd0;
        set_req(1, 1'b1, 4'd0);
        set_req(2, 1'b1, 4'd0);
        set_req(3, 1'b1, 4'd0);
        q_ready = 1'b1;
        run_until_grants(4, 30, "t2_wait");
        req_valid = '0;
        tick();
        q_ready = 1'b0;
        tick();
        tick();
        chk("t2_grant0", 32'(gl(0)), 32'd1);
        chk("t2_grant1", 32'(gl(1)), 32'd2);
        chk("t2_grant2", 32'(gl(2)), 32'd3);
        chk("t2_grant3", 32'(gl(3)), 32'd1);

        // 3: debug port raised mid-burst waits for the 4-word burst, then wins
        do_reset();
        guard_time = 4'd1;
        set_req(1, 1'b1, 4'd3);
        run_until_grants(1, 5, "t3_wait1");
        set_req(0, 1'b1, 4'd0);
        set_req(2, 1'b1, 4'd0);
        set_req(3, 1'b1, 4'd0);
        q_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("t3_grant_x4",  32'(grant_id),  32'd1);
        chk("t3_ready_x4",  32'(req_ready), 32'b0010);
        tick();
        req_valid[1] = 1'b0;
        q_ready      = 1'b0;
        run_until_grants(2, 10, "t3_wait2");
        finish_burst(0);
        run_until_grants(3, 10, "t3_wait3");
        finish_burst(2);
        run_until_grants(4, 10, "t3_wait4");
        finish_burst(3);
        tick();
        chk("t3_words_req1", 32'(wl(0)), 32'd4);
        chk("t3_grant1",     32'(gl(1)), 32'd0);
        chk("t3_grant2",     32'(gl(2)), 32'd2);
        chk("t3_grant3",     32'(gl(3)), 32'd3);

        // 4: watchdog with TIMEOUT=15, q_ready never arrives
        do_reset();
        guard_time = 4'd0;
        set_req(1, 1'b1, 4'd2);
        set_req(2, 1'b1, 4'd0);
        run_until_grants(1, 5, "t4_wait1");
        for (int c = 2; c <= 16; c++) tick();
        chk("t4_no_err_x16",  32'(timeout_err), 32'd0);
        chk("t4_q_valid_x16", 32'(q_valid),     32'd1);
        tick();
        chk("t4_err_pulse",   32'(timeout_err), 32'd1);
        chk("t4_q_valid_gap", 32'(q_valid),     32'd0);
        req_valid[1] = 1'b0;
        tick();
        chk("t4_err_cleared", 32'(timeout_err), 32'd0);
        run_until_grants(2, 10, "t4_wait2");
        chk("t4_next_grant",  32'(gl(1)), 32'd2);
        finish_burst(2);

        // 5: abandon after one word; ready together with valid drop counts
        do_reset();
        guard_time = 4'd0;
        set_req(3, 1'b1, 4'd3);
        run_until_grants(1, 5, "t5_wait1");
        q_ready = 1'b1;
        tick();
        q_ready      = 1'b0;
        req_valid[3] = 1'b0;
        #1;
        chk("t5_q_valid_drop", 32'(q_valid), 32'd0);
        tick();
        chk("t5_busy_gap",     32'(busy),        32'd1);
        chk("t5_no_err",       32'(timeout_err), 32'd0);
        tick();
        chk("t5_idle",         32'(busy),        32'd0);
        chk("t5_words_a",      32'(wl(0)),       32'd1);
        set_req(2, 1'b1, 4'd1);
        run_until_grants(2, 5, "t5_wait2");
        q_ready      = 1'b1;
        req_valid[2] = 1'b0;
        #1;
        chk("t5_ready_on_drop", 32'(req_ready), 32'b0100);
        tick();
        req_valid[2] = 1'b1;
        #1;
        chk("t5_still_xfer",   32'(q_valid), 32'd1);
        tick();
        q_ready      = 1'b0;
        req_valid[2] = 1'b0;
        tick();
        chk("t5_words_b",      32'(wl(1)), 32'd2);

        // 6: async reset mid-XFER, then arbitration restarts from pointer 0
        do_reset();
        guard_time = 4'd3;
        set_req(1, 1'b1, 4'd3);
        set_req(2, 1'b1, 4'd0);
        run_until_grants(1, 5, "t6_wait1");
        tick();
        q_ready = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("t6_q_valid_rst",   32'(q_valid),   32'd0);
        chk("t6_req_ready_rst", 32'(req_ready), 32'd0);
        chk("t6_busy_rst",      32'(busy),      32'd0);
        chk("t6_grant_rst",     32'(grant_id),  32'd0);
        tick();
        tick();
        q_ready = 1'b0;
        set_req(1, 1'b1, 4'd0);
        rst_n = 1'b1;
        run_until_grants(1, 5, "t6_wait2");
        chk("t6_first_grant", 32'(gl(0)), 32'd1);
        finish_burst(1);
        run_until_grants(2, 10, "t6_wait3");
        chk("t6_second_grant", 32'(gl(1)), 32'd2);
        finish_burst(2);
        repeat (6) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "bench did not finish");
    end

endmodule
